// File: rtl/spi_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_bus_arbiter_if
//  Brief    : Requester, SPI-core and status signals shared by the SPI port
//             arbiter and the blocks around it.
//  Revision : 1.0  initial release
// ============================================================================
interface spi_bus_arbiter_if;
  // requester 0 (card init starter)
  logic        req0_lock;
  logic        req0_read;
  logic        req0_write;
  logic [15:0] req0_address;
  logic [31:0] req0_writedata;
  logic [31:0] req0_readdata;
  logic        req0_grant;
  logic        req0_irq;

  // requester 1 (sector read/write sequencer)
  logic        req1_lock;
  logic        req1_read;
  logic        req1_write;
  logic [15:0] req1_address;
  logic [31:0] req1_writedata;
  logic [31:0] req1_readdata;
  logic        req1_grant;
  logic        req1_irq;

  // SPI core side
  logic        m_read;
  logic        m_write;
  logic [15:0] m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        core_irq;

  // status
  logic        busy;
  logic        owner;
  logic        timeout;

  // Requesters and core: drive requests and core responses
  modport master (
    output req0_lock, req0_read, req0_write, req0_address, req0_writedata,
    input  req0_readdata, req0_grant, req0_irq,
    output req1_lock, req1_read, req1_write, req1_address, req1_writedata,
    input  req1_readdata, req1_grant, req1_irq,
    input  m_read, m_write, m_address, m_writedata,
    output m_readdata, core_irq,
    input  busy, owner, timeout
  );

  // Arbiter view
  modport slave (
    input  req0_lock, req0_read, req0_write, req0_address, req0_writedata,
    output req0_readdata, req0_grant, req0_irq,
    input  req1_lock, req1_read, req1_write, req1_address, req1_writedata,
    output req1_readdata, req1_grant, req1_irq,
    output m_read, m_write, m_address, m_writedata,
    input  m_readdata, core_irq,
    output busy, owner, timeout
  );
endinterface
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_bus_arbiter
//  Brief    : Locks the SPI core command port to one of two masters for a
//             whole transaction, routes the core irq to the owner and revokes
//             ownership from a stalled owner.
//  Revision : 1.0  initial release
// ============================================================================
module spi_bus_arbiter #(
  parameter int IDLE_TIMEOUT = 4095,
  parameter int CNT_W        = 12
) (
  input  logic             clk,
  input  logic             rst,
  spi_bus_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] c_idle_timeout = CNT_W'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT0   = 2'd1,
    ST_GRANT1   = 2'd2,
    ST_HANDOVER = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_last;
  logic             w_last_next;
  logic [1:0]       r_blocked;
  logic [1:0]       w_blocked_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_timeout;

  logic w_own0;
  logic w_own1;
  logic w_owner_idx;
  logic w_own_lock;
  logic w_own_strobe;
  logic w_elig0;
  logic w_elig1;

  assign w_own0      = (r_state == ST_GRANT0);
  assign w_own1      = (r_state == ST_GRANT1);
  assign w_owner_idx = w_own1;
  assign w_own_lock  = w_own1 ? bus.req1_lock : bus.req0_lock;
  assign w_own_strobe = w_own0 ? (bus.req0_read | bus.req0_write) :
                        w_own1 ? (bus.req1_read | bus.req1_write) : 1'b0;
  assign w_elig0     = bus.req0_lock & ~r_blocked[0];
  assign w_elig1     = bus.req1_lock & ~r_blocked[1];

  // Next-state, tie-break, idle counter and revocation
  always_comb begin
    w_state_next      = r_state;
    w_last_next       = r_last;
    w_cnt_next        = r_cnt;
    w_timeout         = 1'b0;
    w_blocked_next[0] = bus.req0_lock ? r_blocked[0] : 1'b0;
    w_blocked_next[1] = bus.req1_lock ? r_blocked[1] : 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_elig0 && (!w_elig1 || r_last)) begin
          w_state_next = ST_GRANT0;
          w_last_next  = 1'b0;
          w_cnt_next   = '0;
        end else if (w_elig1) begin
          w_state_next = ST_GRANT1;
          w_last_next  = 1'b1;
          w_cnt_next   = '0;
        end
      end

      ST_GRANT0, ST_GRANT1: begin
        if (r_cnt == c_idle_timeout) begin
          // Revoked owner must drop its lock before it may compete again
          w_timeout                   = 1'b1;
          w_blocked_next[w_owner_idx] = 1'b1;
          w_state_next                = ST_HANDOVER;
          w_cnt_next                  = '0;
        end else if (!w_own_lock) begin
          w_state_next = ST_HANDOVER;
          w_cnt_next   = '0;
        end else if (w_own_strobe || bus.core_irq) begin
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_HANDOVER: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b1;
      r_blocked <= 2'b00;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_last    <= w_last_next;
      r_blocked <= w_blocked_next;
      r_cnt     <= w_cnt_next;
    end
  end

  // Owner's access passes straight through; everything is 0 with no owner
  assign bus.m_read      = w_own0 ? bus.req0_read      : (w_own1 ? bus.req1_read      : 1'b0);
  assign bus.m_write     = w_own0 ? bus.req0_write     : (w_own1 ? bus.req1_write     : 1'b0);
  assign bus.m_address   = w_own0 ? bus.req0_address   : (w_own1 ? bus.req1_address   : 16'h0);
  assign bus.m_writedata = w_own0 ? bus.req0_writedata : (w_own1 ? bus.req1_writedata : 32'h0);

  assign bus.req0_readdata = w_own0 ? bus.m_readdata : 32'h0;
  assign bus.req1_readdata = w_own1 ? bus.m_readdata : 32'h0;
  assign bus.req0_irq      = w_own0 & bus.core_irq;
  assign bus.req1_irq      = w_own1 & bus.core_irq;
  assign bus.req0_grant    = w_own0;
  assign bus.req1_grant    = w_own1;

  assign bus.busy    = w_own0 | w_own1;
  assign bus.owner   = w_own1;
  assign bus.timeout = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_bus_arbiter
//  Brief    : Directed and randomized bench for spi_bus_arbiter against an
//             ownership-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_bus_arbiter;
  localparam int IDLE_TIMEOUT = 4095;
  localparam int CNT_W        = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_bus_arbiter_if bus();

  spi_bus_arbiter #(.IDLE_TIMEOUT(IDLE_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the port, whether a handover gap is pending
  int       m_owner;
  bit       m_handover;
  int       m_last;
  bit [1:0] m_blocked;
  int       m_idle;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_handover = 1'b0;
    m_last     = 1;
    m_blocked  = 2'b00;
    m_idle     = 0;
  endtask

  task automatic model_advance();
    bit [1:0] lk, stb, old_blk;
    bit e0, e1;
    int pick;
    lk      = {bus.req1_lock, bus.req0_lock};
    stb     = {bus.req1_read | bus.req1_write, bus.req0_read | bus.req0_write};
    old_blk = m_blocked;
    for (int i = 0; i < 2; i++) if (!lk[i]) m_blocked[i] = 1'b0;
    if (m_owner >= 0) begin
      if (m_idle == IDLE_TIMEOUT) begin
        m_blocked[m_owner] = 1'b1;
        m_owner    = -1;
        m_handover = 1'b1;
      end else if (!lk[m_owner]) begin
        m_owner    = -1;
        m_handover = 1'b1;
      end else if (stb[m_owner] || bus.core_irq) begin
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end else if (m_handover) begin
      m_handover = 1'b0;
    end else begin
      e0 = lk[0] && !old_blk[0];
      e1 = lk[1] && !old_blk[1];
      if (e0 && e1) pick = 1 - m_last;
      else if (e0)  pick = 0;
      else if (e1)  pick = 1;
      else          pick = -1;
      if (pick >= 0) begin
        m_owner = pick;
        m_last  = pick;
        m_idle  = 0;
      end
    end
  endtask

  // Single compare process: outputs vs model every cycle, then step the model
  always @(negedge clk) begin
    logic [1:0]  e_grant, e_irq, e_stb;
    logic [31:0] e_rd0, e_rd1, e_wd;
    logic [15:0] e_addr;
    logic [2:0]  e_stat;
    if (rst) model_reset();
    e_grant = 2'b00; e_irq = 2'b00; e_stb = 2'b00;
    e_rd0 = 32'h0; e_rd1 = 32'h0; e_wd = 32'h0; e_addr = 16'h0; e_stat = 3'b000;
    if (m_owner == 0) begin
      e_grant = 2'b01;
      e_irq   = {1'b0, bus.core_irq};
      e_rd0   = bus.m_readdata;
      e_stb   = {bus.req0_read, bus.req0_write};
      e_addr  = bus.req0_address;
      e_wd    = bus.req0_writedata;
    end else if (m_owner == 1) begin
      e_grant = 2'b10;
      e_irq   = {bus.core_irq, 1'b0};
      e_rd1   = bus.m_readdata;
      e_stb   = {bus.req1_read, bus.req1_write};
      e_addr  = bus.req1_address;
      e_wd    = bus.req1_writedata;
    end
    if (m_owner >= 0)
      e_stat = {1'b1, (m_owner == 1), (m_idle == IDLE_TIMEOUT)};
    chk("grant",     32'({bus.req1_grant, bus.req0_grant}), 32'(e_grant));
    chk("irq",       32'({bus.req1_irq, bus.req0_irq}),     32'(e_irq));
    chk("readdata0", bus.req0_readdata,                     e_rd0);
    chk("readdata1", bus.req1_readdata,                     e_rd1);
    chk("m_strobe",  32'({bus.m_read, bus.m_write}),        32'(e_stb));
    chk("m_address", 32'(bus.m_address),                    32'(e_addr));
    chk("m_wdata",   bus.m_writedata,                       e_wd);
    chk("status",    32'({bus.busy, bus.owner, bus.timeout}), 32'(e_stat));
    if (!rst) model_advance();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    bus.req0_read = 1'b0; bus.req0_write = 1'b0;
    bus.req1_read = 1'b0; bus.req1_write = 1'b0;
    bus.core_irq  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req0_lock = 1'b0; bus.req1_lock = 1'b0;
    bus.req0_address = 16'h0; bus.req0_writedata = 32'h0;
    bus.req1_address = 16'h0; bus.req1_writedata = 32'h0;
    bus.m_readdata = 32'h0;
    clear_strobes();
    repeat (3) step();
    rst = 1'b0;
    chk("reset_busy", 32'(bus.busy), 0);

    // Lock0 alone; req1's early write and later write never reach the core
    bus.req0_lock = 1'b1;
    bus.req1_write = 1'b1; bus.req1_address = 16'h9; bus.req1_writedata = 32'hDEAD;
    #1 chk("t1_pregrant_mwrite", 32'(bus.m_write), 0);
    step();
    chk("t1_grant0", 32'(bus.req0_grant), 1);
    bus.req0_write = 1'b1; bus.req0_address = 16'h6; bus.req0_writedata = 32'h0;
    bus.req1_lock = 1'b1;
    #1;
    chk("t1_m_write",   32'(bus.m_write), 1);
    chk("t1_m_address", 32'(bus.m_address), 32'h6);
    chk("t1_m_wdata",   bus.m_writedata, 32'h0);
    step();
    clear_strobes();
    bus.req0_lock = 1'b0;
    chk("t1_nonpreempt", 32'(bus.req1_grant), 0);
    step();
    chk("t2_handover_busy", 32'(bus.busy), 0);
    step();
    chk("t2_idle_grant1", 32'(bus.req1_grant), 0);
    step();
    chk("t2_grant1", 32'({bus.busy, bus.owner}), 32'h3);

    // irq and readdata routed only to owner 1
    bus.core_irq = 1'b1; bus.m_readdata = 32'hA5;
    #1;
    chk("t3_irq", 32'({bus.req1_irq, bus.req0_irq}), 32'h2);
    chk("t3_rd1", bus.req1_readdata, 32'hA5);
    chk("t3_rd0", bus.req0_readdata, 32'h0);
    step();
    bus.core_irq = 1'b0; bus.req1_lock = 1'b0;
    step();
    bus.core_irq = 1'b1;
    #1 chk("t5_handover_irq", 32'({bus.req1_irq, bus.req0_irq}), 0);
    step();
    bus.core_irq = 1'b0;
    bus.req0_lock = 1'b1; bus.req1_lock = 1'b1;
    step();
    chk("t2_tie_grant0", 32'({bus.req1_grant, bus.req0_grant}), 32'h1);

    // Stalled owner 0 is revoked; req1 takes over; req0 blocked until lock drops
    repeat (IDLE_TIMEOUT) step();
    chk("t4_timeout", 32'({bus.timeout, bus.req0_grant}), 32'h3);
    step();
    chk("t4_after", 32'({bus.timeout, bus.req0_grant}), 0);
    step();
    step();
    chk("t4_grant1", 32'(bus.req1_grant), 1);
    bus.req1_lock = 1'b0;
    repeat (3) step();
    chk("t4_blocked0", 32'(bus.req0_grant), 0);
    bus.req0_lock = 1'b0;
    step();
    bus.req0_lock = 1'b1;
    step();
    chk("t4_unblocked0", 32'(bus.req0_grant), 1);

    // Async reset mid-write clears every output at once and resets the tie-break
    bus.req0_write = 1'b1; bus.req0_address = 16'h3; bus.req0_writedata = 32'h1234;
    #1 chk("t6_write", 32'(bus.m_write), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_out", 32'({bus.req0_grant, bus.m_write, bus.busy, bus.m_address}), 0);
    chk("t6_rst_wd", bus.m_writedata, 0);
    step();
    clear_strobes();
    step();
    rst = 1'b0;
    bus.req1_lock = 1'b1;
    step();
    chk("t6_tie_grant0", 32'({bus.req1_grant, bus.req0_grant}), 32'h1);

    // Randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 6000; c++) begin
      step();
      if ($urandom_range(0, 15) == 0) bus.req0_lock = ~bus.req0_lock;
      if ($urandom_range(0, 15) == 0) bus.req1_lock = ~bus.req1_lock;
      bus.req0_read      = ($urandom_range(0, 5) == 0);
      bus.req0_write     = ($urandom_range(0, 5) == 0);
      bus.req1_read      = ($urandom_range(0, 5) == 0);
      bus.req1_write     = ($urandom_range(0, 5) == 0);
      bus.req0_address   = 16'($urandom);
      bus.req1_address   = 16'($urandom);
      bus.req0_writedata = $urandom;
      bus.req1_writedata = $urandom;
      bus.m_readdata     = $urandom;
      bus.core_irq       = ($urandom_range(0, 7) == 0);
    end
    clear_strobes();
    bus.req0_lock = 1'b0; bus.req1_lock = 1'b0;
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
